// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, data-cache request
// handshake with stall generation, write-back data select and the MEM/WB register.
module memory_stage #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              flush,
  input  logic [WORD_W-1:0] ex_nPC,
  input  logic [WORD_W-1:0] ex_ALUOut,
  input  logic [WORD_W-1:0] ex_rtdat,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic              ex_regWr,
  input  logic [1:0]        ex_regSel,
  input  logic [REG_AW-1:0] ex_regDst,
  input  logic              ex_halt,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              wb_regWr,
  output logic [REG_AW-1:0] wb_regDst,
  output logic [WORD_W-1:0] wb_wdat,
  output logic              wb_halt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic [WORD_W-1:0] m_nPC, m_ALUOut, m_rtdat, load_buf;
  logic              m_dREN, m_dWEN, m_regWr, m_halt;
  logic [1:0]        m_regSel;
  logic [REG_AW-1:0] m_regDst;
  logic              advance;
  logic [WORD_W-1:0] wdat_sel;

  assign mem_stall = (state == REQ);
  assign advance   = ihit & ~mem_stall;
  assign dmemREN   = mem_stall & m_dREN;
  assign dmemWEN   = mem_stall & m_dWEN;
  assign dmemaddr  = m_ALUOut;
  assign dmemstore = m_rtdat;

  always_comb begin
    wdat_sel = m_ALUOut;
    case (m_regSel)
      2'd1:    wdat_sel = load_buf;
      2'd2:    wdat_sel = m_nPC;
      default: wdat_sel = m_ALUOut;
    endcase
  end

  // EX/MEM register and request FSM; advance is impossible while in REQ, so a
  // flush can never abort an open memory access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      m_nPC    <= '0;
      m_ALUOut <= '0;
      m_rtdat  <= '0;
      m_dREN   <= 1'b0;
      m_dWEN   <= 1'b0;
      m_regWr  <= 1'b0;
      m_regSel <= 2'd0;
      m_regDst <= '0;
      m_halt   <= 1'b0;
      load_buf <= '0;
    end else if (advance) begin
      if (flush) begin
        state    <= IDLE;
        m_nPC    <= '0;
        m_ALUOut <= '0;
        m_rtdat  <= '0;
        m_dREN   <= 1'b0;
        m_dWEN   <= 1'b0;
        m_regWr  <= 1'b0;
        m_regSel <= 2'd0;
        m_regDst <= '0;
        m_halt   <= 1'b0;
      end else begin
        state    <= (ex_dREN | ex_dWEN) ? REQ : IDLE;
        m_nPC    <= ex_nPC;
        m_ALUOut <= ex_ALUOut;
        m_rtdat  <= ex_rtdat;
        m_dREN   <= ex_dREN;
        m_dWEN   <= ex_dWEN;
        m_regWr  <= ex_regWr;
        m_regSel <= ex_regSel;
        m_regDst <= ex_regDst;
        m_halt   <= ex_halt;
      end
    end else if (mem_stall && dhit) begin
      load_buf <= dmemload;
      state    <= HOLD;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_regWr  <= 1'b0;
      wb_regDst <= '0;
      wb_wdat   <= '0;
      wb_halt   <= 1'b0;
    end else if (advance) begin
      wb_regWr  <= m_regWr;
      wb_regDst <= m_regDst;
      wb_wdat   <= wdat_sel;
      wb_halt   <= wb_halt | m_halt;
    end
  end

endmodule
